vga_tile_renderer: RTL and testbench

- Pixel stage placed directly downstream of the VGA timing generator. Consumes bright/hSync/vSync and produces 8-bit RGB (3-3-2) for an 80x60 grid of 8x8 character tiles.
- Fetches each tile code from an external synchronous tile RAM, then the glyph row from an external synchronous glyph ROM.
- Overlays a blinking block cursor.
- Delays sync/bright outputs so they stay aligned with the pixel data.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_pixel_counter.sv | 70 +++++++
 rtl/vga_tile_renderer.sv | 148 ++++++++++++++
 tb/tb_vga_tile_renderer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared geometry, address widths and colours for the tile
//               renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int TILE_W       = 8;
    localparam int TILE_H       = 8;
    localparam int TILE_COLS    = 80;
    localparam int TILE_ROWS    = 60;

    localparam int TILE_ADDR_W  = 13;
    localparam int GLYPH_ADDR_W = 10;
    localparam int COUNT_W      = 10;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_counter
// Description : Tracks the pixel x/y position and frame count from the
//               bright/vsync timing inputs; produces the cursor blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_counter #(
    parameter int BLINK_BIT = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       bright_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blink_on
);
    import vga_pkg::*;

    // Only bits up to BLINK_BIT influence the blink phase, so the frame
    // counter is kept just wide enough to hold that bit.
    localparam int FRAME_W = BLINK_BIT + 1;

    logic                 r_bright_d;
    logic                 r_vsync_d;
    logic [COUNT_W-1:0]   r_x;
    logic [COUNT_W-1:0]   r_y;
    logic [FRAME_W-1:0]   r_frame;
    logic                 w_bright_fall;
    logic                 w_vsync_fall;

    assign w_bright_fall = r_bright_d & ~bright_in;
    assign w_vsync_fall  = r_vsync_d  & ~vsync_in;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_bright_d <= 1'b0;
            r_vsync_d  <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_frame    <= '0;
        end else begin
            r_bright_d <= bright_in;
            r_vsync_d  <= vsync_in;

            if (bright_in) begin
                if (r_x != COUNT_MAX)
                    r_x <= r_x + 10'd1;
            end else if (w_bright_fall) begin
                r_x <= '0;
            end

            // vsync low overrides a same-cycle end-of-line increment
            if (!vsync_in)
                r_y <= '0;
            else if (w_bright_fall && (r_y != COUNT_MAX))
                r_y <= r_y + 10'd1;

            if (w_vsync_fall)
                r_frame <= r_frame + 1'b1;
        end
    end

    assign x        = r_x;
    assign y        = r_y;
    assign blink_on = r_frame[BLINK_BIT];

endmodule
`default_nettype wire

// File: rtl/vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : vga_tile_renderer
// Description : Three-stage tile/glyph fetch pipeline producing RGB332 pixels
//               with a blinking block cursor and matching sync delay.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_tile_renderer #(
    parameter int BLINK_BIT = 4,
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             bright_in,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    output logic [vga_pkg::TILE_ADDR_W-1:0]  tile_addr,
    input  logic [7:0]                       tile_data,
    output logic [vga_pkg::GLYPH_ADDR_W-1:0] glyph_addr,
    input  logic [7:0]                       glyph_data,
    input  logic [7:0]                       fg_color,
    input  logic [7:0]                       bg_color,
    input  logic                             cursor_en,
    input  logic [6:0]                       cursor_col,
    input  logic [5:0]                       cursor_row,
    output logic [7:0]                       rgb,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             bright_out
);
    import vga_pkg::*;

    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_blink_on;

    vga_pixel_counter #(
        .BLINK_BIT (BLINK_BIT)
    ) u_pixel_counter (
        .clock     (clock),
        .clear     (clear),
        .bright_in (bright_in),
        .vsync_in  (vsync_in),
        .x         (w_x),
        .y         (w_y),
        .blink_on  (w_blink_on)
    );

    // Stage 0: tile address from the current position (row*80 = row*64 + row*16)
    logic [6:0] w_col;
    logic [6:0] w_row;
    logic       w_oor;

    assign w_col     = w_x[9:3];
    assign w_row     = w_y[9:3];
    assign w_oor     = (w_x >= 10'(H_ACTIVE)) || (w_y >= 10'(V_ACTIVE));
    assign tile_addr = w_oor ? '0
                     : ({w_row, 6'b0} + {2'b0, w_row, 4'b0} + {6'b0, w_col});

    logic [2:0] r_xs0, r_ys0;
    logic [6:0] r_col0, r_row0;
    logic       r_oor0, r_bright0, r_hs0, r_vs0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_xs0     <= '0;
            r_ys0     <= '0;
            r_col0    <= '0;
            r_row0    <= '0;
            r_oor0    <= 1'b0;
            r_bright0 <= 1'b0;
            r_hs0     <= 1'b1;
            r_vs0     <= 1'b1;
        end else begin
            r_xs0     <= w_x[2:0];
            r_ys0     <= w_y[2:0];
            r_col0    <= w_col;
            r_row0    <= w_row;
            r_oor0    <= w_oor;
            r_bright0 <= bright_in;
            r_hs0     <= hsync_in;
            r_vs0     <= vsync_in;
        end
    end

    // Stage 1: tile code has arrived; form the glyph row address
    logic       w_hit;
    logic [2:0] r_xs1;
    logic       r_inv1, r_hit1, r_oor1, r_bright1, r_hs1, r_vs1;

    assign glyph_addr = {tile_data[6:0], r_ys0};
    assign w_hit      = (r_col0 == cursor_col) && (r_row0 == {1'b0, cursor_row});

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_xs1     <= '0;
            r_inv1    <= 1'b0;
            r_hit1    <= 1'b0;
            r_oor1    <= 1'b0;
            r_bright1 <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
        end else begin
            r_xs1     <= r_xs0;
            r_inv1    <= tile_data[7];
            r_hit1    <= w_hit;
            r_oor1    <= r_oor0;
            r_bright1 <= r_bright0;
            r_hs1     <= r_hs0;
            r_vs1     <= r_vs0;
        end
    end

    // Stage 2: pick the pixel bit (bit7 is leftmost) and apply inverse/cursor
    logic [2:0] w_bit_idx;
    logic       w_pix;
    logic [7:0] w_rgb;

    assign w_bit_idx = 3'd7 - r_xs1;
    assign w_pix     = glyph_data[w_bit_idx] ^ r_inv1 ^ (cursor_en & w_blink_on & r_hit1);
    assign w_rgb     = !r_bright1 ? BLACK
                     : (r_oor1 ? bg_color : (w_pix ? fg_color : bg_color));

    logic [7:0] r_rgb;
    logic       r_hsync_out, r_vsync_out, r_bright_out;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_rgb        <= BLACK;
            r_hsync_out  <= 1'b1;
            r_vsync_out  <= 1'b1;
            r_bright_out <= 1'b0;
        end else begin
            r_rgb        <= w_rgb;
            r_hsync_out  <= r_hs1;
            r_vsync_out  <= r_vs1;
            r_bright_out <= r_bright1;
        end
    end

    assign rgb        = r_rgb;
    assign hsync_out  = r_hsync_out;
    assign vsync_out  = r_vsync_out;
    assign bright_out = r_bright_out;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_tile_renderer
// Description : Self-checking bench: reference pixel model with scoreboard,
//               table-driven glyph vectors and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_tile_renderer;

    localparam int BLINK_BIT = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        bright_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [12:0] tile_addr;
    logic [7:0]  tile_data = 8'h00;
    logic [9:0]  glyph_addr;
    logic [7:0]  glyph_data = 8'h00;
    logic [7:0]  fg_color = 8'hE0, bg_color = 8'h03;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = 7'd5;
    logic [5:0]  cursor_row = 6'd2;
    logic [7:0]  rgb;
    logic        hsync_out, vsync_out, bright_out;

    vga_tile_renderer #(.BLINK_BIT(BLINK_BIT), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clock      (clock),
        .clear      (clear),
        .bright_in  (bright_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .tile_addr  (tile_addr),
        .tile_data  (tile_data),
        .glyph_addr (glyph_addr),
        .glyph_data (glyph_data),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .bright_out (bright_out)
    );

    always #5 clock = ~clock;

    // External synchronous memories, one clock read latency
    logic [7:0] tram [0:8191];
    logic [7:0] grom [0:1023];
    always @(posedge clock) begin
        tile_data  <= tram[tile_addr];
        glyph_data <= grom[glyph_addr];
    end

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] rgb;
        logic       b, h, v;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] hist [int];

    // Reference model state
    int         mx = 0, my = 0;
    logic       pb = 1'b0, pv = 1'b1;
    logic [7:0] mframe = 8'd0;
    logic [9:0] ga_exp = '0;
    logic       ga_valid = 1'b0;
    int         lstart = 0;

    always @(negedge clock) begin
        if (clear) begin
            hist[cyc] = rgb;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("pipe_out", {rgb, bright_out, hsync_out, vsync_out}, {e.rgb, e.b, e.h, e.v});
                if (!bright_out)
                    chk("blank_rgb", rgb, 8'h00);
            end
        end
    end

    task automatic drive(input logic b, input logic h, input logic v);
        exp_t       e;
        int         ta;
        logic [7:0] t, g;
        logic       p, oor;
        bright_in = b; hsync_in = h; vsync_in = v;
        oor = (mx >= 640) || (my >= 480);
        ta  = oor ? 0 : (my / 8) * 80 + mx / 8;
        chk("tile_addr", tile_addr, ta);
        if (ga_valid) chk("glyph_addr", glyph_addr, ga_exp);
        t        = tram[ta];
        ga_exp   = {t[6:0], 3'(my % 8)};
        ga_valid = 1'b1;
        e.due = cyc + 3; e.b = b; e.h = h; e.v = v;
        if (!b)
            e.rgb = 8'h00;
        else if (oor)
            e.rgb = bg_color;
        else begin
            g = grom[{t[6:0], 3'(my % 8)}];
            p = g[7 - (mx % 8)] ^ t[7] ^
                (cursor_en & mframe[BLINK_BIT] & (mx / 8 == cursor_col) & (my / 8 == cursor_row));
            e.rgb = p ? fg_color : bg_color;
        end
        sbq.push_back(e);
        if (!v) my = 0;
        else if (pb && !b && my < 1023) my++;
        if (b) begin
            if (mx < 1023) mx++;
        end else if (pb) mx = 0;
        if (pv && !v) mframe++;
        pb = b; pv = v;
        @(posedge clock); #1;
    endtask

    task automatic tail();
        repeat (2) drive(1'b0, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic line(input int n);
        lstart = cyc;
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1);
        tail();
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic chk_blank(input string name);
        chk(name, {rgb, bright_out, hsync_out, vsync_out, tile_addr},
                  {8'h00, 1'b0, 1'b1, 1'b1, 13'd0});
    endtask

    task automatic release_reset();
        bright_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        sbq.delete();
        mx = 0; my = 0; pb = 1'b0; pv = 1'b1; mframe = 8'd0; ga_valid = 1'b0;
        @(negedge clock) clear = 1'b1;
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [7:0]  tile, glyph, fg, bg;
        logic [63:0] px;
    } vec_t;
    vec_t vt [4];

    initial begin
        logic [7:0] exp8;

        vt[0] = '{8'h01, 8'h81, 8'hE0, 8'h03, 64'hE0030303030303E0};
        vt[1] = '{8'h81, 8'h81, 8'hE0, 8'h03, 64'h03E0E0E0E0E0E003};
        vt[2] = '{8'h02, 8'hF0, 8'hFF, 8'h00, 64'hFFFFFFFF00000000};
        vt[3] = '{8'h03, 8'h55, 8'h1C, 8'hE3, 64'hE31CE31CE31CE31C};

        for (int i = 0; i < 8192; i++) tram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) grom[i] = 8'($urandom);

        // Reset asserted asynchronously while a line is in progress
        bright_in = 1'b1;
        @(posedge clock); #3 clear = 1'b0; #1;
        chk_blank("reset_async");
        for (int i = 0; i < 3; i++) begin
            hsync_in = ~hsync_in;
            @(posedge clock); #1;
            chk_blank("reset_hold");
        end
        release_reset();

        // First line after reset: column 0 for x 0..7, column 1 at x=8
        repeat (8) drive(1'b1, 1'b1, 1'b1);
        chk("first_col1", tile_addr, 13'd1);
        repeat (4) drive(1'b1, 1'b1, 1'b1);
        tail();

        // Row 1, column 2 and its glyph address
        tram[82] = 8'h41;
        vs_pulse();
        repeat (9) line(1);
        repeat (17) drive(1'b1, 1'b1, 1'b1);
        chk("tile_y9_x17", tile_addr, 13'd82);
        drive(1'b1, 1'b1, 1'b1);
        chk("glyph_y9_x17", glyph_addr, 10'h209);
        repeat (6) drive(1'b1, 1'b1, 1'b1);
        tail();

        // Table-driven glyph patterns at cell (0,0), glyph row 0
        for (int k = 0; k < 4; k++) begin
            tram[0] = vt[k].tile;
            grom[{vt[k].tile[6:0], 3'd0}] = vt[k].glyph;
            fg_color = vt[k].fg;
            bg_color = vt[k].bg;
            vs_pulse();
            line(8);
            for (int i = 0; i < 8; i++) begin
                exp8 = vt[k].px[63 - 8 * i -: 8];
                chk("table_px", hist[lstart + 3 + i], exp8);
            end
        end

        // Cursor at (5,2) with blink phase on, then off after 16 more frames
        fg_color = 8'hE0; bg_color = 8'h03;
        tram[2 * 80 + 5] = 8'h05;
        grom[{7'h05, 3'd0}] = 8'h00;
        cursor_en = 1'b1;
        while (!mframe[BLINK_BIT]) vs_pulse();
        repeat (16) line(1);
        line(48);
        for (int i = 40; i < 48; i++) chk("cursor_on", hist[lstart + 3 + i], 8'hE0);
        while (mframe[BLINK_BIT]) vs_pulse();
        repeat (16) line(1);
        line(48);
        for (int i = 40; i < 48; i++) chk("cursor_off", hist[lstart + 3 + i], 8'h03);
        cursor_en = 1'b0;

        // Over-long line: pixels beyond the active width show background
        vs_pulse();
        line(700);
        chk("oor_px", hist[lstart + 3 + 660], bg_color);

        // vsync low on the same cycle bright falls: y clear takes priority
        vs_pulse();
        repeat (8) line(1);
        repeat (4) drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        repeat (9) drive(1'b1, 1'b1, 1'b1);
        chk("y_clear_wins", tile_addr, 13'd1);
        tail();

        // Reset in the middle of active pixels flushes the pipeline
        repeat (5) drive(1'b1, 1'b1, 1'b1);
        #2 clear = 1'b0; #1;
        chk_blank("reset_midline");
        release_reset();

        // Random sync/bright patterns: outputs are exact 3-cycle copies
        repeat (300)
            drive(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 8) != 0));
        repeat (6) drive(1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
`default_nettype wire
